div_seq_param: RTL



---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 23 ++
 rtl/div_seq_param.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional signed mode is enabled in the top level by defining DIV_SIGNED_EN.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    localparam int MAX_WIDTH = 64;

    // Quotient reported for a zero divisor: all ones at the requested width.
    function automatic logic [MAX_WIDTH-1:0] dbz_quotient(input int width);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only if it did not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    assign w_shift = {i_rem, i_bit};
    assign w_trial = w_shift - {1'b0, i_divisor};
    // Borrow is the MSB of the WIDTH+1 bit difference; no borrow -> quotient bit 1.
    assign o_qbit  = ~w_trial[WIDTH];
    // While rem < divisor holds, a kept remainder always fits in WIDTH bits.
    assign o_rem   = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done
// handshake and divide-by-zero flag. Define DIV_SIGNED_EN to add the
// signed_mode input (magnitude division with sign fixup on completion).
module div_seq_param
    import div_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
`ifdef DIV_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] DBZ_Q    = WIDTH'(dbz_quotient(WIDTH));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;
    logic             r_dbz_out;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;
    logic             w_accept;

    // Start is only looked at in IDLE; anything seen in CALC/FINISH is dropped.
    assign w_accept = start && (r_state == IDLE);

`ifdef DIV_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_neg = signed_mode & dividend_in[WIDTH-1];
    assign w_b_neg = signed_mode & divisor_in[WIDTH-1];
    // MIN has no positive twin, but its unsigned pattern is the right magnitude.
    assign w_a_mag = w_a_neg ? -dividend_in : dividend_in;
    assign w_b_mag = w_b_neg ? -divisor_in  : divisor_in;
    // Divide-by-zero results are reported raw, never sign-adjusted.
    assign w_q_fix = (r_neg_q && !r_dbz) ? -r_quo : r_quo;
    assign w_r_fix = (r_neg_r && !r_dbz) ? -r_rem : r_rem;

    // Result signs: quotient truncates toward zero, remainder follows dividend.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end
`else
    assign w_a_mag = dividend_in;
    assign w_b_mag = divisor_in;
    assign w_q_fix = r_quo;
    assign w_r_fix = r_rem;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    // Control FSM plus iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dbz     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_q_out   <= '0;
            r_r_out   <= '0;
            r_dbz_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= w_accept;
                    if (w_accept) begin
                        r_dbz_out <= 1'b0;
                        r_cnt     <= '0;
                        if (divisor_in == '0) begin
                            // Skip iterations; FINISH publishes the fixed result.
                            r_quo   <= DBZ_Q;
                            r_rem   <= dividend_in;
                            r_dbz   <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_dvd   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_rem   <= '0;
                            r_quo   <= '0;
                            r_dbz   <= 1'b0;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_q};
                    r_dvd <= r_dvd << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) r_state <= FINISH;
                end
                FINISH: begin
                    r_q_out   <= w_q_fix;
                    r_r_out   <= w_r_fix;
                    r_dbz_out <= r_dbz;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign quotient_out  = r_q_out;
    assign remainder_out = r_r_out;
    assign div_by_zero   = r_dbz_out;

endmodule
